// File: rtl/ldpc_3gpp_enc_types.sv
// Types shared across the 3GPP LDPC encoder blocks.
package ldpc_3gpp_enc_types;

    localparam int cHB_W = 9;

    // Circular-shift value of one base-graph entry
    typedef logic [cHB_W-1:0] mm_hb_value_t;

    // B-column shift values for the three p2 parity rows
    typedef mm_hb_value_t [2:0] hb_row_t;

    // Read strobes: start/end of frame, start/end of row (packet)
    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

endpackage

// File: rtl/ldpc_3gpp_enc_rowword_cnt.sv
// Row (0..2) and word (0..N-1) position of the next p2 read, plus strobe decode.
module ldpc_3gpp_enc_rowword_cnt #(
    parameter int pADDR_W = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               iclr,
    input  logic               iadv,
    input  logic [pADDR_W-1:0] iword_last,
    output logic [1:0]         orow,
    output logic [pADDR_W-1:0] oword,
    output logic               osop,
    output logic               oeop,
    output logic               osof,
    output logic               oeof
);

    // Advance one word per read; wrap the word at row end and the row after row 2
    always_ff @(posedge iclk) begin
        if (ireset) begin
            orow  <= '0;
            oword <= '0;
        end else if (iclkena) begin
            if (iclr) begin
                orow  <= '0;
                oword <= '0;
            end else if (iadv) begin
                if (oeop) begin
                    oword <= '0;
                    orow  <= (orow == 2'd2) ? 2'd0 : orow + 2'd1;
                end else begin
                    oword <= oword + 1'b1;
                end
            end
        end
    end

    assign osop = (oword == '0);
    assign oeop = (oword == iword_last);
    assign osof = osop & (orow == 2'd0);
    assign oeof = oeop & (orow == 2'd2);

endmodule

// File: rtl/ldpc_3gpp_enc_p2_ctrl.sv
// p2 stage read sequencer: waits for A*u' and p1 sources, walks 3 rows word by
// word gated per row by output-buffer space, drains the p2 pipe, pulses done.
import ldpc_3gpp_enc_types::*;

module ldpc_3gpp_enc_p2_ctrl #(
    parameter int pADDR_W = 8,
    parameter int pHB_W   = 9,
    parameter int pPIPE   = 0
) (
    input  logic                   iclk,
    input  logic                   ireset,
    input  logic                   iclkena,
    input  logic                   istart,
    input  logic [pADDR_W-1:0]     iword_num,
    input  logic [2:0][pHB_W-1:0]  ihb,
    input  logic                   iau_rdy,
    input  logic                   ip1_rdy,
    input  logic                   iobuf_rdy,
    output logic                   oread,
    output logic                   orstart,
    output logic                   orval,
    output strb_t                  orstrb,
    output logic [1:0]             orrow,
    output logic [2:0][pHB_W-1:0]  orHb,
    output logic                   obusy,
    output logic                   odone
);

    // read alignment (3+pPIPE) plus two output registers
    localparam int cDRAIN   = 5 + pPIPE;
    localparam int cDRAIN_W = $clog2(cDRAIN + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_SRC, WAIT_OBUF, READ, DRAIN, DONE
    } state_t;

    state_t               state;
    logic [pADDR_W-1:0]   word_last;
    logic [cDRAIN_W-1:0]  drain_cnt;
    logic                 accept;
    logic                 emit;
    logic [1:0]           cnt_row;
    logic [pADDR_W-1:0]   cnt_word;
    logic                 cnt_sop, cnt_eop, cnt_sof, cnt_eof;

    ldpc_3gpp_enc_rowword_cnt #(.pADDR_W(pADDR_W)) u_cnt (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .iclr       (accept),
        .iadv       (emit),
        .iword_last (word_last),
        .orow       (cnt_row),
        .oword      (cnt_word),
        .osop       (cnt_sop),
        .oeop       (cnt_eop),
        .osof       (cnt_sof),
        .oeof       (cnt_eof)
    );

    // Decide whether the next cycle carries a read word; READ falls through to
    // the next row without a gap when the output buffer is already ready
    always_comb begin
        accept = 1'b0;
        emit   = 1'b0;
        case (state)
            IDLE, DONE: accept = istart;
            WAIT_SRC:   emit   = iau_rdy & ip1_rdy & iobuf_rdy;
            WAIT_OBUF:  emit   = iobuf_rdy;
            READ:       emit   = ~orstrb.eop | ((orrow != 2'd2) & iobuf_rdy);
            default:    emit   = 1'b0;
        endcase
    end

    // Frame FSM with registered read-port and status outputs
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state     <= IDLE;
            word_last <= '0;
            drain_cnt <= '0;
            oread     <= 1'b0;
            orstart   <= 1'b0;
            orstrb    <= '0;
            orrow     <= '0;
            orHb      <= '0;
            obusy     <= 1'b0;
            odone     <= 1'b0;
        end else if (iclkena) begin
            oread   <= emit;
            orstart <= emit & cnt_sop;
            orstrb  <= emit ? strb_t'{cnt_sof, cnt_sop, cnt_eop, cnt_eof} : '0;
            if (emit)
                orrow <= cnt_row;
            odone <= 1'b0;
            if (accept) begin
                word_last <= (iword_num == '0) ? '0 : iword_num - 1'b1;
                orHb      <= ihb;
                obusy     <= 1'b1;
                state     <= WAIT_SRC;
            end else begin
                case (state)
                    WAIT_SRC: begin
                        if (iau_rdy & ip1_rdy)
                            state <= iobuf_rdy ? READ : WAIT_OBUF;
                    end
                    WAIT_OBUF: begin
                        if (iobuf_rdy)
                            state <= READ;
                    end
                    READ: begin
                        if (orstrb.eop) begin
                            if (orrow == 2'd2) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end else if (!iobuf_rdy) begin
                                state <= WAIT_OBUF;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == cDRAIN_W'(cDRAIN - 1)) begin
                            state <= DONE;
                            odone <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        obusy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign orval = oread;

endmodule

// File: tb/tb_ldpc_3gpp_enc_p2_ctrl.sv
// Directed table-driven bench for the p2 read sequencer.
import ldpc_3gpp_enc_types::*;

module tb_ldpc_3gpp_enc_p2_ctrl;

    localparam int AW = 8;

    typedef struct packed {
        logic       rd;
        logic       rs;
        logic [3:0] strb;
        logic [1:0] row;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        logic          rst, en, st, au, p1, ob;
        logic [AW-1:0] wn;
        logic [26:0]   hb;
        logic          hbchk;
        logic [26:0]   xhb;
        exp_t          e;
        logic          c1;
        exp_t          e1;
        int            t;
    } vec_t;

    localparam logic [26:0] HB_A = 27'h1234567;
    localparam logic [26:0] HB_B = 27'h0abcdef;
    localparam logic [26:0] HB_J = 27'h5555555;

    logic iclk = 1'b0;
    logic ireset, iclkena, istart, iau_rdy, ip1_rdy, iobuf_rdy;
    logic [AW-1:0]     iword_num;
    logic [2:0][8:0]   ihb;
    logic oread0, orstart0, orval0, obusy0, odone0;
    logic oread1, orstart1, orval1, obusy1, odone1;
    strb_t orstrb0, orstrb1;
    logic [1:0] orrow0, orrow1;
    logic [2:0][8:0] orHb0, orHb1;

    int checks = 0;
    int fails  = 0;
    vec_t tbl[$];
    string scen;

    always #5 iclk = ~iclk;

    ldpc_3gpp_enc_p2_ctrl #(.pADDR_W(AW), .pHB_W(9), .pPIPE(0)) dut0 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
        .iword_num(iword_num), .ihb(ihb), .iau_rdy(iau_rdy), .ip1_rdy(ip1_rdy),
        .iobuf_rdy(iobuf_rdy), .oread(oread0), .orstart(orstart0), .orval(orval0),
        .orstrb(orstrb0), .orrow(orrow0), .orHb(orHb0), .obusy(obusy0), .odone(odone0));

    ldpc_3gpp_enc_p2_ctrl #(.pADDR_W(AW), .pHB_W(9), .pPIPE(1)) dut1 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
        .iword_num(iword_num), .ihb(ihb), .iau_rdy(iau_rdy), .ip1_rdy(ip1_rdy),
        .iobuf_rdy(iobuf_rdy), .oread(oread1), .orstart(orstart1), .orval(orval1),
        .orstrb(orstrb1), .orrow(orrow1), .orHb(orHb1), .obusy(obusy1), .odone(odone1));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected outputs at cycle t for a frame accepted at ta whose rows start at
    // r0/r1/r2 (n words each, no stall inside a row)
    function automatic exp_t frame_exp(int t, int ta, int r0, int r1, int r2, int n, int pipe);
        exp_t e;
        int rs[3];
        int w, tdone;
        rs[0] = r0; rs[1] = r1; rs[2] = r2;
        e = '0;
        for (int r = 0; r < 3; r++) begin
            if (t >= rs[r] && t < rs[r] + n) begin
                w      = t - rs[r];
                e.rd   = 1'b1;
                e.rs   = (w == 0);
                e.row  = 2'(r);
                e.strb = {r == 0 && w == 0, w == 0, w == n - 1, r == 2 && w == n - 1};
            end
        end
        tdone  = r2 + n - 1 + 6 + pipe;
        e.busy = (t > ta) && (t <= tdone);
        e.done = (t == tdone);
        return e;
    endfunction

    function automatic exp_t nom(int t);
        return frame_exp(t, 0, 2, 6, 10, 4, 0);
    endfunction

    task automatic add(input int t, input logic rst, en, st, au, p1, ob,
                       input logic [AW-1:0] wn, input logic [26:0] hb,
                       input logic hbchk, input logic [26:0] xhb,
                       input exp_t e, input logic c1, input exp_t e1);
        vec_t v;
        v.t = t; v.rst = rst; v.en = en; v.st = st; v.au = au; v.p1 = p1; v.ob = ob;
        v.wn = wn; v.hb = hb; v.hbchk = hbchk; v.xhb = xhb; v.e = e; v.c1 = c1; v.e1 = e1;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        ireset = 1'b1; iclkena = 1'b1; istart = 1'b0;
        iau_rdy = 1'b0; ip1_rdy = 1'b0; iobuf_rdy = 1'b0;
        iword_num = '0; ihb = '0;
        repeat (2) @(posedge iclk);
        #1 ireset = 1'b0;
    endtask

    // Apply each record for one cycle and compare outputs mid-cycle
    task automatic run_tbl();
        logic [10:0] act, exp;
        foreach (tbl[i]) begin
            ireset = tbl[i].rst; iclkena = tbl[i].en; istart = tbl[i].st;
            iau_rdy = tbl[i].au; ip1_rdy = tbl[i].p1; iobuf_rdy = tbl[i].ob;
            iword_num = tbl[i].wn; ihb = tbl[i].hb;
            @(negedge iclk);
            act = {oread0, orval0, orstart0, orstrb0, tbl[i].e.rd ? orrow0 : 2'd0, obusy0, odone0};
            exp = {tbl[i].e.rd, tbl[i].e.rd, tbl[i].e.rs, tbl[i].e.strb, tbl[i].e.row,
                   tbl[i].e.busy, tbl[i].e.done};
            cmp($sformatf("%s t%0d {rd,val,rs,strb,row,busy,done}", scen, tbl[i].t), 32'(act), 32'(exp));
            if (tbl[i].hbchk)
                cmp($sformatf("%s t%0d orHb", scen, tbl[i].t), 32'(orHb0), 32'(tbl[i].xhb));
            if (tbl[i].c1) begin
                act = {oread1, orval1, orstart1, orstrb1, tbl[i].e1.rd ? orrow1 : 2'd0, obusy1, odone1};
                exp = {tbl[i].e1.rd, tbl[i].e1.rd, tbl[i].e1.rs, tbl[i].e1.strb, tbl[i].e1.row,
                       tbl[i].e1.busy, tbl[i].e1.done};
                cmp($sformatf("%s t%0d pipe1 outputs", scen, tbl[i].t), 32'(act), 32'(exp));
            end
            @(posedge iclk);
            #1;
        end
        tbl.delete();
    endtask

    initial begin
        do_reset();
        @(negedge iclk);
        cmp("reset outputs", 32'({oread0, orval0, orstart0, orstrb0, orrow0, obusy0, odone0}), 32'd0);
        cmp("reset orHb", 32'(orHb0), 32'd0);
        @(posedge iclk); #1;

        // Nominal N=4, pPIPE 0 and 1; istart at t6 (mid READ) must be ignored
        scen = "nominal";
        for (int t = 0; t <= 21; t++)
            add(t, 0, 1, t == 0 || t == 6, 1, 1, 1, 8'd4, (t == 0) ? HB_A : HB_J,
                t >= 1, HB_A, nom(t), 1, frame_exp(t, 0, 2, 6, 10, 4, 1));
        run_tbl();

        // p1 buffer late: first read one cycle after p1 ready is sampled
        scen = "srcgate"; do_reset();
        for (int t = 0; t <= 30; t++)
            add(t, 0, 1, t == 0, 1, t >= 11, 1, 8'd4, HB_A, 0, HB_A,
                frame_exp(t, 0, 12, 16, 20, 4, 0), 0, '0);
        run_tbl();

        // iword_num = 0 behaves as single-word rows
        scen = "n0"; do_reset();
        for (int t = 0; t <= 11; t++)
            add(t, 0, 1, t == 0, 1, 1, 1, 8'd0, HB_A, 0, HB_A,
                frame_exp(t, 0, 2, 3, 4, 1, 0), 0, '0);
        run_tbl();

        // Output buffer not ready t4..t7: row 0 finishes, row 1 waits
        scen = "obuf"; do_reset();
        for (int t = 0; t <= 23; t++)
            add(t, 0, 1, t == 0, 1, 1, !(t >= 4 && t <= 7), 8'd4, HB_A, 0, HB_A,
                frame_exp(t, 0, 2, 9, 13, 4, 0), 0, '0);
        run_tbl();

        // istart in the DONE cycle starts a new frame with new shift values
        scen = "restart"; do_reset();
        for (int t = 0; t <= 40; t++)
            add(t, 0, 1, t == 0 || t == 19, 1, 1, 1, 8'd4,
                (t == 0) ? HB_A : (t == 19) ? HB_B : HB_J, t >= 1, (t <= 19) ? HB_A : HB_B,
                (t <= 19) ? nom(t) : frame_exp(t, 19, 21, 25, 29, 4, 0), 0, '0);
        run_tbl();

        // Sync reset while reading row 1: immediate abort, no done
        scen = "midreset"; do_reset();
        for (int t = 0; t <= 18; t++)
            add(t, t == 7, 1, t == 0, 1, 1, 1, 8'd4, HB_A, 0, HB_A,
                (t < 8) ? nom(t) : exp_t'('0), 0, '0);
        run_tbl();

        // Clock enable low t4..t6: outputs freeze, sequence resumes 3 cycles late
        scen = "clkena"; do_reset();
        for (int t = 0; t <= 24; t++)
            add(t, 0, !(t >= 4 && t <= 6), t == 0, 1, 1, 1, 8'd4, HB_A, t >= 1, HB_A,
                (t <= 4) ? nom(t) : (t <= 7) ? nom(4) : nom(t - 3), 0, '0);
        run_tbl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
